// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  ANODE_OFF  = 4'b1111;
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;

  typedef logic [1:0] digit_sel_t;

endpackage

// File: rtl/seven_segment.sv
// Hex nibble to active-low seven-segment cathode pattern; bit 0 = CA, bit 6 = CG.
module seven_segment (
  input  logic [3:0] hex,
  output logic [6:0] segment
);

  always_comb begin
    segment = 7'b1111111;
    unique case (hex)
      4'h0: segment = 7'b1000000;
      4'h1: segment = 7'b1111001;
      4'h2: segment = 7'b0100100;
      4'h3: segment = 7'b0110000;
      4'h4: segment = 7'b0011001;
      4'h5: segment = 7'b0010010;
      4'h6: segment = 7'b0000010;
      4'h7: segment = 7'b1111000;
      4'h8: segment = 7'b0000000;
      4'h9: segment = 7'b0010000;
      4'hA: segment = 7'b0001000;
      4'hB: segment = 7'b0000011;
      4'hC: segment = 7'b1000110;
      4'hD: segment = 7'b0100001;
      4'hE: segment = 7'b0000110;
      4'hF: segment = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seven_segment_display.sv
// Four-digit time-multiplexed common-anode driver with per-scan input snapshot
// and an anode-off guard interval at the start of every digit slot.
module seven_segment_display
  import seven_seg_pkg::*;
#(
  parameter int unsigned COUNT_BITS   = 17,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  segment,
  output logic        dp,
  output logic [3:0]  anode
);

  localparam logic [COUNT_BITS-3:0] GUARD = (COUNT_BITS-2)'(GUARD_CYCLES);

  logic [COUNT_BITS-1:0] count_q;
  logic [15:0]           data_q;
  logic [3:0]            blank_q;
  logic [3:0]            dp_q;

  digit_sel_t            digit_sel;
  logic [COUNT_BITS-3:0] slot_pos;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic                  guard;
  logic                  scan_end;

  assign digit_sel = count_q[COUNT_BITS-1:COUNT_BITS-2];
  assign slot_pos  = count_q[COUNT_BITS-3:0];
  assign nibble    = data_q[{digit_sel, 2'b00} +: 4];
  assign scan_end  = &count_q;
  assign guard     = (slot_pos < GUARD) || blank_q[digit_sel];

  seven_segment u_decoder (
    .hex     (nibble),
    .segment (glyph)
  );

  // Snapshot loads on the last count of a scan so a whole scan shows one value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      data_q  <= '0;
      blank_q <= '1;
      dp_q    <= '0;
      anode   <= ANODE_OFF;
      segment <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      count_q <= count_q + 1'b1;
      if (scan_end) begin
        data_q  <= data_in;
        blank_q <= blank_in;
        dp_q    <= dp_in;
      end
      if (guard) begin
        anode   <= ANODE_OFF;
        segment <= SEG_BLANK;
        dp      <= 1'b1;
      end else begin
        anode   <= ~(4'b0001 << digit_sel);
        segment <= glyph;
        dp      <= ~dp_q[digit_sel];
      end
    end
  end

endmodule
